// File: rtl/full_adder_unit.sv
// Registered ripple-carry full adder: {c, s} = in1 + in2 + cin, captured one clock
// after a valid input, with a two's-complement overflow flag for the same addition.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s_next;
  logic             c_next;
  logic             ovf_next;

  assign k[0] = cin;

  // One classic full-adder cell per bit; k[i] is the carry into bit i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s_next[i] = in1[i] ^ in2[i] ^ k[i];
    assign k[i+1]    = (in1[i] & in2[i]) | (k[i] & (in1[i] ^ in2[i]));
  end

  assign c_next   = k[WIDTH];
  assign ovf_next = k[WIDTH] ^ k[WIDTH-1];

  // Result registers only load on a valid input, so junk on idle cycles never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s   <= s_next;
        c   <= c_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH = 1, 4 and 8: directed tables,
// hold and reset sequences, and a randomized stream against an arithmetic reference.
module tb_full_adder_unit;

  logic clk;
  logic rst_n;

  logic       v1, ci1, c1, o1, ov1;
  logic [0:0] a1, b1, s1;
  logic       v4, ci4, c4, o4, ov4;
  logic [3:0] a4, b4, s4;
  logic       v8, ci8, c8, o8, ov8;
  logic [7:0] a8, b8, s8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tab1[8];
  vec_t tab4[3];

  full_adder_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in1(a1), .in2(b1), .cin(ci1),
    .s(s1), .c(c1), .ovf(o1), .out_valid(ov1)
  );

  full_adder_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in1(a4), .in2(b4), .cin(ci4),
    .s(s4), .c(c4), .ovf(o4), .out_valid(ov4)
  );

  full_adder_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in1(a8), .in2(b8), .cin(ci8),
    .s(s8), .c(c8), .ovf(o8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer sum; overflow when the signed sum leaves the signed range.
  function automatic void refAdd(input int w, input longint a, input longint b, input int ci,
                                 output logic [7:0] es, output logic ec, output logic eo);
    longint one = 1;
    longint full = (one << w);
    longint u = a + b + ci;
    longint sa = (a >= (full >> 1)) ? a - full : a;
    longint sb = (b >= (full >> 1)) ? b - full : b;
    longint ss = sa + sb + ci;
    es = 8'(u % full);
    ec = (u >= full);
    eo = (ss > (full >> 1) - 1) || (ss < -(full >> 1));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input int w, input logic [7:0] es,
                          input logic ec, input logic eo, input logic ev);
    case (w)
      1: begin
        checkOutput({name, ".s"}, 64'(s1), 64'(es[0]));
        checkOutput({name, ".c"}, 64'(c1), 64'(ec));
        checkOutput({name, ".ovf"}, 64'(o1), 64'(eo));
        checkOutput({name, ".out_valid"}, 64'(ov1), 64'(ev));
      end
      4: begin
        checkOutput({name, ".s"}, 64'(s4), 64'(es[3:0]));
        checkOutput({name, ".c"}, 64'(c4), 64'(ec));
        checkOutput({name, ".ovf"}, 64'(o4), 64'(eo));
        checkOutput({name, ".out_valid"}, 64'(ov4), 64'(ev));
      end
      default: begin
        checkOutput({name, ".s"}, 64'(s8), 64'(es));
        checkOutput({name, ".c"}, 64'(c8), 64'(ec));
        checkOutput({name, ".ovf"}, 64'(o8), 64'(eo));
        checkOutput({name, ".out_valid"}, 64'(ov8), 64'(ev));
      end
    endcase
  endtask

  task automatic applyStimulus(input int w, input logic v, input logic [7:0] a,
                               input logic [7:0] b, input logic ci);
    v1 = 1'b0;
    v4 = 1'b0;
    v8 = 1'b0;
    case (w)
      1: begin v1 = v; a1 = a[0:0]; b1 = b[0:0]; ci1 = ci; end
      4: begin v4 = v; a4 = a[3:0]; b4 = b[3:0]; ci4 = ci; end
      default: begin v8 = v; a8 = a; b8 = b; ci8 = ci; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] es, ra, rb;
    logic       ec, eo, ev, rv, rc;

    v1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    v4 = 0; a4 = 0; b4 = 0; ci4 = 0;
    v8 = 0; a8 = 0; b8 = 0; ci8 = 0;

    tab1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    tab1[1] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    tab1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
    tab1[3] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
    tab1[4] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
    tab1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
    tab1[6] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    tab1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

    tab4[0] = '{8'hF, 8'h1, 1'b0, 8'h0, 1'b1, 1'b0};
    tab4[1] = '{8'h7, 8'h1, 1'b0, 8'h8, 1'b0, 1'b1};
    tab4[2] = '{8'hF, 8'hF, 1'b1, 8'hF, 1'b1, 1'b0};

    // Reset held with valid inputs present: everything stays cleared.
    rst_n = 1'b0;
    applyStimulus(1, 1'b1, 8'd1, 8'd1, 1'b1);
    tick();
    tick();
    checkAll("reset_w1", 1, 8'd0, 1'b0, 1'b0, 1'b0);
    checkAll("reset_w4", 4, 8'd0, 1'b0, 1'b0, 1'b0);
    checkAll("reset_w8", 8, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1, tab1[i].a, tab1[i].b, tab1[i].ci);
      tick();
      checkAll($sformatf("w1_vec%0d", i), 1, tab1[i].es, tab1[i].ec, tab1[i].eo, 1'b1);
    end

    // Hold: result 1+1+0 stays put while idle inputs toggle (including unknowns).
    applyStimulus(1, 1'b1, 8'd1, 8'd1, 1'b0);
    tick();
    checkAll("hold_load", 1, 8'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) applyStimulus(1, 1'b0, 8'hxx, 8'hxx, 1'bx);
      else        applyStimulus(1, 1'b0, 8'(i), 8'(i), i[0]);
      tick();
      checkAll($sformatf("hold_idle%0d", i), 1, 8'd0, 1'b1, 1'b1, 1'b0);
    end

    // 4-bit carry, overflow and wrap-around corners.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4, 1'b1, tab4[i].a, tab4[i].b, tab4[i].ci);
      tick();
      checkAll($sformatf("w4_vec%0d", i), 4, tab4[i].es, tab4[i].ec, tab4[i].eo, 1'b1);
    end

    // Asynchronous reset mid-cycle after a result, then release with and without input.
    applyStimulus(1, 1'b1, 8'd1, 8'd1, 1'b1);
    tick();
    checkAll("w1_pre_reset", 1, 8'd1, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkAll("w1_async_clear", 1, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    applyStimulus(1, 1'b0, 8'd1, 8'd1, 1'b1);
    tick();
    checkAll("w1_post_release_idle", 1, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 8'd0, 8'd1, 1'b1);
    tick();
    checkAll("w1_post_release_valid", 1, 8'd0, 1'b1, 1'b0, 1'b1);

    // Randomized 8-bit stream with idle gaps, scored against the arithmetic reference.
    es = 8'd0; ec = 1'b0; eo = 1'b0; ev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      if (i == 10) begin rv = 1'b1; ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
      applyStimulus(8, rv, ra, rb, rc);
      tick();
      if (rv) refAdd(8, longint'(ra), longint'(rb), int'(rc), es, ec, eo);
      ev = rv;
      checkAll($sformatf("rand%0d", i), 8, es, ec, eo, ev);
    end

    // Reset pulse in the middle of an 8-bit stream.
    applyStimulus(8, 1'b1, 8'h12, 8'h34, 1'b1);
    tick();
    checkAll("w8_stream", 8, 8'h47, 1'b0, 1'b0, 1'b1);
    applyStimulus(8, 1'b1, 8'hF0, 8'h20, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkAll("w8_async_clear", 8, 8'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    applyStimulus(8, 1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    checkAll("w8_post_release", 8, 8'h80, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
